pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_sup_pkg.sv | 27 ++
 rtl/pll_lock_supervisor_sync2.sv | 28 ++
 rtl/pll_lock_supervisor.sv | 173 +++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
// The state encoding and default timing constants live here so the
// supervisor and any companion logic agree on them.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PULSE     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  localparam int DEF_RST_CYCLES     = 16;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 65536;
  localparam int DEF_MAX_RETRIES    = 3;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync2.sv
// Two-flop synchronizer for asynchronous status inputs.
// Flops clear on asynchronous reset so a stale "high" never survives reset.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a synchronized lock,
// demands a run of consecutive locked cycles, then releases the core reset.
// Lock loss in RUN re-sequences; repeated lock timeouts latch FAULT.
// Optional feature macro: PLL_SUP_LOSS_CNT_EN enables the lock-loss counter;
// without it loss_cnt is constant zero and no counter register exists.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retries,
  output logic [7:0] loss_cnt
);

  localparam int CNT_SPAN = max3(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam int CW       = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    MAX_R    = 2'(MAX_RETRIES);

  logic        lk_s;
  pll_state_e  state_r;
  pll_state_e  state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic [1:0]  retries_r;
  logic [1:0]  retries_nxt_s;
  logic        pll_rst_r;
  logic        sys_rst_n_r;
  logic        ready_r;
  logic        fault_r;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

  // State, shared counter, retry count and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_PULSE;
      cnt_r       <= '0;
      retries_r   <= 2'd0;
      pll_rst_r   <= 1'b1;
      sys_rst_n_r <= 1'b0;
      ready_r     <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      retries_r   <= retries_nxt_s;
      pll_rst_r   <= (state_nxt_s == ST_PULSE) || (state_nxt_s == ST_FAULT);
      sys_rst_n_r <= (state_nxt_s == ST_RUN);
      ready_r     <= (state_nxt_s == ST_RUN);
      fault_r     <= (state_nxt_s == ST_FAULT);
    end
  end

  // Next-state, counter and retry decisions; restart overrides everything.
  // The lock seen in WAIT_LOCK is the first of the required consecutive
  // locked cycles, so STABLE starts counting from one.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    retries_nxt_s = retries_r;
    if (restart) begin
      state_nxt_s   = ST_PULSE;
      cnt_nxt_s     = '0;
      retries_nxt_s = 2'd0;
    end else begin
      case (state_r)
        ST_PULSE: begin
          if (cnt_r >= RST_LAST) begin
            state_nxt_s = ST_WAIT_LOCK;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          if (lk_s) begin
            state_nxt_s = ST_STABLE;
            cnt_nxt_s   = CNT_ONE;
          end else if (cnt_r >= TO_LAST) begin
            cnt_nxt_s = '0;
            if (retries_r < MAX_R) begin
              state_nxt_s   = ST_PULSE;
              retries_nxt_s = retries_r + 2'd1;
            end else begin
              state_nxt_s = ST_FAULT;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_STABLE: begin
          if (!lk_s) begin
            state_nxt_s = ST_WAIT_LOCK;
            cnt_nxt_s   = '0;
          end else if (cnt_r >= STB_LAST) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lk_s) begin
            state_nxt_s   = ST_PULSE;
            cnt_nxt_s     = '0;
            retries_nxt_s = 2'd0;
          end else begin
            cnt_nxt_s = '0;
          end
        end
        ST_FAULT: begin
          cnt_nxt_s = '0;
        end
        default: begin
          state_nxt_s   = ST_PULSE;
          cnt_nxt_s     = '0;
          retries_nxt_s = 2'd0;
        end
      endcase
    end
  end

  assign pll_rst   = pll_rst_r;
  assign sys_rst_n = sys_rst_n_r;
  assign ready     = ready_r;
  assign fault     = fault_r;
  assign retries   = retries_r;

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0] loss_cnt_r;
  logic       loss_evt_s;

  // A lock loss only counts when it actually causes the RUN exit.
  assign loss_evt_s = (state_r == ST_RUN) && !lk_s && !restart;

  // Saturating count of lock losses observed in RUN.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt_r <= 8'd0;
    end else if (loss_evt_s && (loss_cnt_r != 8'hFF)) begin
      loss_cnt_r <= loss_cnt_r + 8'd1;
    end else begin
      loss_cnt_r <= loss_cnt_r;
    end
  end

  assign loss_cnt = loss_cnt_r;
`else
  assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor (TIMEOUT_CYCLES=100).
// Expected output values are queued with the refclk cycle at which they must
// hold; a monitor on the falling edge pops and compares them.
module tb_pll_lock_supervisor;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [1:0] retries;
  logic [7:0] loss_cnt;

`ifdef PLL_SUP_LOSS_CNT_EN
  localparam int EXP_LOSS = 1;
`else
  localparam int EXP_LOSS = 0;
`endif

  localparam int S_PLL_RST = 0;
  localparam int S_SYS_RST = 1;
  localparam int S_READY   = 2;
  localparam int S_FAULT   = 3;
  localparam int S_RETRIES = 4;
  localparam int S_LOSS    = 5;

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string tag;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  pll_lock_supervisor #(
    .RST_CYCLES     (16),
    .STABLE_CYCLES  (1024),
    .TIMEOUT_CYCLES (100),
    .MAX_RETRIES    (3)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fault      (fault),
    .retries    (retries),
    .loss_cnt   (loss_cnt)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  // Rising-edge counter used as the scoreboard time base.
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic int sig_val(input int sel);
    case (sel)
      S_PLL_RST: return int'(pll_rst);
      S_SYS_RST: return int'(sys_rst_n);
      S_READY:   return int'(ready);
      S_FAULT:   return int'(fault);
      S_RETRIES: return int'(retries);
      S_LOSS:    return int'(loss_cnt);
      default:   return -1;
    endcase
  endfunction

  task automatic push_exp(input int c, input int sel, input int val, input string tag);
    exp_t e;
    int   i;
    e.cyc = c;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    i = sb_q.size();
    while (i > 0 && sb_q[i-1].cyc > c) i--;
    sb_q.insert(i, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Monitor: compare every queued expectation due at this cycle.
  initial begin
    exp_t e;
    int   obs;
    forever begin
      @(negedge refclk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e   = sb_q.pop_front();
        obs = (e.cyc == cyc) ? sig_val(e.sel) : -1;
        check_val(e.tag, obs, e.val);
      end
    end
  end

  initial begin
    int c0, l0, r0, d0, f0, base;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;

    // Reset values while rst_n is held low.
    step(3);
    check_val("rst_pll_rst", int'(pll_rst), 1);
    check_val("rst_sys_rst_n", int'(sys_rst_n), 0);
    check_val("rst_ready", int'(ready), 0);
    check_val("rst_fault", int'(fault), 0);
    check_val("rst_retries", int'(retries), 0);
    check_val("rst_loss_cnt", int'(loss_cnt), 0);

    // Normal lock: pulse cycles 0-15, lock at cycle 40, RUN after 2+1024.
    rst_n = 1'b1;
    c0 = cyc;
    push_exp(c0 + 1,  S_PLL_RST, 1, "t1_pulse_first");
    push_exp(c0 + 15, S_PLL_RST, 1, "t1_pulse_last");
    push_exp(c0 + 16, S_PLL_RST, 0, "t1_pulse_end");
    push_exp(c0 + 16, S_SYS_RST, 0, "t1_sysrst_wait");
    step(40);
    pll_locked = 1'b1;
    l0 = cyc;
    push_exp(l0 + 1025, S_READY,   0, "t1_ready_early");
    push_exp(l0 + 1025, S_SYS_RST, 0, "t1_sysrst_early");
    push_exp(l0 + 1026, S_READY,   1, "t1_ready_rise");
    push_exp(l0 + 1026, S_SYS_RST, 1, "t1_sysrst_rise");
    push_exp(l0 + 1026, S_RETRIES, 0, "t1_retries");
    push_exp(l0 + 1026, S_PLL_RST, 0, "t1_pll_rst_run");

    // Lock loss in RUN: sys_rst_n drops, new pulse, loss counted.
    step(1040);
    pll_locked = 1'b0;
    r0 = cyc;
    push_exp(r0 + 2,  S_SYS_RST, 1, "t3_sysrst_still");
    push_exp(r0 + 3,  S_SYS_RST, 0, "t3_sysrst_drop");
    push_exp(r0 + 3,  S_READY,   0, "t3_ready_drop");
    push_exp(r0 + 3,  S_PLL_RST, 1, "t3_pulse_start");
    push_exp(r0 + 3,  S_LOSS,    EXP_LOSS, "t3_loss_cnt");
    push_exp(r0 + 3,  S_RETRIES, 0, "t3_retries");
    push_exp(r0 + 18, S_PLL_RST, 1, "t3_pulse_last");
    push_exp(r0 + 19, S_PLL_RST, 0, "t3_pulse_end");
    step(10);
    pll_locked = 1'b1;

    // Lock glitch of 5 cycles during STABLE: no retry, stable count restarts.
    step(90);
    pll_locked = 1'b0;
    d0 = cyc;
    push_exp(d0 + 5,    S_PLL_RST, 0, "t4_no_pulse");
    push_exp(d0 + 10,   S_RETRIES, 0, "t4_no_retry");
    push_exp(d0 + 1030, S_READY,   0, "t4_ready_early");
    push_exp(d0 + 1031, S_READY,   1, "t4_ready_rise");
    push_exp(d0 + 1031, S_SYS_RST, 1, "t4_sysrst_rise");
    push_exp(d0 + 1031, S_LOSS,    EXP_LOSS, "t4_loss_kept");
    step(5);
    pll_locked = 1'b1;
    step(1040);

    // Asynchronous reset mid-RUN: outputs return to reset values at once.
    check_val("t5_pre_ready", int'(ready), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t5_pll_rst", int'(pll_rst), 1);
    check_val("t5_sys_rst_n", int'(sys_rst_n), 0);
    check_val("t5_ready", int'(ready), 0);
    check_val("t5_fault", int'(fault), 0);
    check_val("t5_retries", int'(retries), 0);
    check_val("t5_loss_cnt", int'(loss_cnt), 0);

    // No lock at all: 4 pulses (initial + 3 retries), then FAULT latched.
    pll_locked = 1'b0;
    step(3);
    rst_n = 1'b1;
    c0 = cyc;
    for (int n = 0; n < 4; n++) begin
      base = c0 + 116 * n;
      push_exp(base + 1,   S_PLL_RST, 1, $sformatf("t2_pulse%0d_first", n));
      push_exp(base + 15,  S_PLL_RST, 1, $sformatf("t2_pulse%0d_last", n));
      push_exp(base + 16,  S_PLL_RST, 0, $sformatf("t2_pulse%0d_end", n));
      push_exp(base + 16,  S_RETRIES, n, $sformatf("t2_retries%0d", n));
      push_exp(base + 115, S_PLL_RST, 0, $sformatf("t2_wait%0d_end", n));
    end
    push_exp(c0 + 463, S_FAULT,   0, "t2_fault_early");
    push_exp(c0 + 464, S_FAULT,   1, "t2_fault_set");
    push_exp(c0 + 464, S_RETRIES, 3, "t2_retries_final");
    push_exp(c0 + 464, S_PLL_RST, 1, "t2_pll_rst_fault");
    push_exp(c0 + 464, S_READY,   0, "t2_ready_fault");
    push_exp(c0 + 599, S_PLL_RST, 1, "t2_pll_rst_stuck");
    push_exp(c0 + 599, S_FAULT,   1, "t2_fault_latched");
    step(600);

    // Restart out of FAULT.
    restart = 1'b1;
    f0 = cyc;
    push_exp(f0 + 1,  S_FAULT,   0, "t6_fault_clr");
    push_exp(f0 + 1,  S_RETRIES, 0, "t6_retries_clr");
    push_exp(f0 + 1,  S_PLL_RST, 1, "t6_pulse_start");
    push_exp(f0 + 16, S_PLL_RST, 1, "t6_pulse_last");
    push_exp(f0 + 17, S_PLL_RST, 0, "t6_pulse_end");
    push_exp(f0 + 117, S_RETRIES, 1, "t6_retry_one");
    push_exp(f0 + 464, S_RETRIES, 3, "t6_retries_pre");
    step(1);
    restart = 1'b0;

    // Restart on the same cycle as the final timeout: restart wins.
    step(463);
    restart = 1'b1;
    push_exp(f0 + 465, S_FAULT,   0, "t6b_no_fault");
    push_exp(f0 + 465, S_RETRIES, 0, "t6b_retries_clr");
    push_exp(f0 + 465, S_PLL_RST, 1, "t6b_pulse_start");
    push_exp(f0 + 480, S_PLL_RST, 1, "t6b_pulse_last");
    push_exp(f0 + 481, S_PLL_RST, 0, "t6b_pulse_end");
    push_exp(f0 + 481, S_FAULT,   0, "t6b_fault_stays_low");
    step(1);
    restart = 1'b0;
    step(30);

    check_val("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
